online_div_residue_sequencer: RTL and testbench

- Sequences the three-operand signed-digit residue adder (four_bits_parallel_adder, plus/minus redundant form) across the iterations of one online division.
- Owns the residue register and accepts one operand pair per iteration over a valid/ready handshake.
- Applies each adder result as the next residue, shifted by one radix-2 position.
- Emits one signed quotient digit per iteration, taken from the adder's compare (sign) output, over a valid/ready handshake.

---
 rtl/online_div_residue_sequencer_pkg.sv | 22 ++
 rtl/online_div_residue_sequencer_adder.sv | 36 +++
 rtl/online_div_residue_sequencer.sv | 147 ++++++++++++++
 tb/tb_online_div_residue_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/online_div_residue_sequencer_pkg.sv
// Shared control definitions for the online-division residue sequencer:
// FSM state encoding, quotient-digit encoding and counter sizing.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        EVAL = 2'b10,
        DONE = 2'b11
    } state_e;

    // {plus, minus} encoding of a single signed quotient digit
    localparam logic [1:0] DIGIT_POS = 2'b10;
    localparam logic [1:0] DIGIT_NEG = 2'b01;

    function automatic int cnt_width(input int iter);
        int w;
        w = $clog2(iter + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/online_div_residue_sequencer_adder.sv
// Three-operand signed-digit adder: plus and minus rails are summed independently,
// carries out of each rail are exposed, and compare flags a negative total.
module four_bits_parallel_adder #(
    parameter int bits = 64
) (
    input  logic [bits-1:0] a_plus,
    input  logic [bits-1:0] a_minus,
    input  logic [bits-1:0] b_plus,
    input  logic [bits-1:0] b_minus,
    input  logic [bits-1:0] c_plus,
    input  logic [bits-1:0] c_minus,
    input  logic [1:0]      cin_one,
    input  logic [1:0]      cin_two,
    output logic [bits-1:0] results_plus,
    output logic [bits-1:0] results_minus,
    output logic [1:0]      cout_one,
    output logic [1:0]      cout_two,
    output logic            compare
);

    // Two guard bits cover the worst case of three full-scale operands plus carry-in.
    logic [bits+1:0] sum_plus;
    logic [bits+1:0] sum_minus;

    assign sum_plus  = {2'b00, a_plus}  + {2'b00, b_plus}  + {2'b00, c_plus}
                     + {{bits{1'b0}}, cin_one};
    assign sum_minus = {2'b00, a_minus} + {2'b00, b_minus} + {2'b00, c_minus}
                     + {{bits{1'b0}}, cin_two};

    assign results_plus  = sum_plus[bits-1:0];
    assign results_minus = sum_minus[bits-1:0];
    assign cout_one      = sum_plus[bits+1:bits];
    assign cout_two      = sum_minus[bits+1:bits];
    assign compare       = (sum_plus < sum_minus);

endmodule

// File: rtl/online_div_residue_sequencer.sv
// Online-division residue sequencer: accepts one operand pair per iteration,
// folds it into the shifted residue and emits one signed quotient digit.
module online_div_residue_sequencer
    import div_ctrl_pkg::*;
#(
    parameter int BITS = 64,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] x_plus,
    input  logic [BITS-1:0] x_minus,
    input  logic [BITS-1:0] y_plus,
    input  logic [BITS-1:0] y_minus,
    output logic            q_valid,
    input  logic            q_ready,
    output logic            q_plus,
    output logic            q_minus,
    output logic [BITS-1:0] res_plus,
    output logic [BITS-1:0] res_minus,
    output logic            ovf
);

    localparam int              CNT_W = cnt_width(ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    state_e            state_q, state_d;
    logic [BITS-1:0]   res_plus_q, res_plus_d;
    logic [BITS-1:0]   res_minus_q, res_minus_d;
    logic [BITS-1:0]   xp_q, xp_d, xm_q, xm_d, yp_q, yp_d, ym_q, ym_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [BITS-1:0]   sum_plus, sum_minus;
    logic [1:0]        cout_one, cout_two;
    logic              compare;

    four_bits_parallel_adder #(
        .bits (BITS)
    ) u_adder (
        .a_plus        (xp_q),
        .a_minus       (xm_q),
        .b_plus        (yp_q),
        .b_minus       (ym_q),
        .c_plus        (res_plus_q),
        .c_minus       (res_minus_q),
        .cin_one       (2'b00),
        .cin_two       (2'b00),
        .results_plus  (sum_plus),
        .results_minus (sum_minus),
        .cout_one      (cout_one),
        .cout_two      (cout_two),
        .compare       (compare)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            res_plus_q  <= '0;
            res_minus_q <= '0;
            xp_q        <= '0;
            xm_q        <= '0;
            yp_q        <= '0;
            ym_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_plus_q  <= res_plus_d;
            res_minus_q <= res_minus_d;
            xp_q        <= xp_d;
            xm_q        <= xm_d;
            yp_q        <= yp_d;
            ym_q        <= ym_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        res_plus_d  = res_plus_q;
        res_minus_d = res_minus_q;
        xp_d        = xp_q;
        xm_d        = xm_q;
        yp_d        = yp_q;
        ym_d        = ym_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    res_plus_d  = '0;
                    res_minus_d = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = STEP;
                end
            end
            STEP: begin
                if (in_valid) begin
                    xp_d    = x_plus;
                    xm_d    = x_minus;
                    yp_d    = y_plus;
                    ym_d    = y_minus;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (q_ready) begin
                    // Next residue is the sum scaled by the radix; the MSB is discarded.
                    res_plus_d  = {sum_plus[BITS-2:0], 1'b0};
                    res_minus_d = {sum_minus[BITS-2:0], 1'b0};
                    ovf_d       = ovf_q | (|cout_one) | (|cout_two);
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = (cnt_q == LAST) ? DONE : STEP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == STEP) || (state_q == EVAL);
        done     = (state_q == DONE);
        in_ready = (state_q == STEP);
        q_valid  = (state_q == EVAL);
        {q_plus, q_minus} = 2'b00;
        if (state_q == EVAL) begin
            {q_plus, q_minus} = compare ? DIGIT_NEG : DIGIT_POS;
        end
    end

    assign res_plus  = res_plus_q;
    assign res_minus = res_minus_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_online_div_residue_sequencer.sv
// Directed bench for the online-division residue sequencer (BITS=8, ITER=4)
// with a queue of expected digits/residues built from an independent model.
module tb_online_div_residue_sequencer;

    localparam int BITS = 8;
    localparam int ITER = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            busy, done;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [BITS-1:0] x_plus = '0, x_minus = '0, y_plus = '0, y_minus = '0;
    logic            q_valid;
    logic            q_ready = 1'b1;
    logic            q_plus, q_minus;
    logic [BITS-1:0] res_plus, res_minus;
    logic            ovf;

    online_div_residue_sequencer #(.BITS(BITS), .ITER(ITER)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_plus    (x_plus),
        .x_minus   (x_minus),
        .y_plus    (y_plus),
        .y_minus   (y_minus),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_plus    (q_plus),
        .q_minus   (q_minus),
        .res_plus  (res_plus),
        .res_minus (res_minus),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      dig;
        logic [BITS-1:0] rp;
        logic [BITS-1:0] rm;
        logic            ov;
    } exp_t;

    exp_t            sb[$];
    logic [BITS-1:0] m_rp, m_rm;
    logic            m_ovf;
    int              n_assert = 0;
    int              n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns at the falling edge where inputs are driven and outputs sampled.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_rp = '0; m_rm = '0; m_ovf = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        chk("start_ovf_clr", ovf, 0);
        chk("start_res_plus", res_plus, 0);
        chk("start_res_minus", res_minus, 0);
    endtask

    task automatic send_pair(input logic [BITS-1:0] xp, input logic [BITS-1:0] xm,
                             input logic [BITS-1:0] yp, input logic [BITS-1:0] ym,
                             input int stall, input bit stray, input bit last);
        logic [BITS+1:0] sp, sm;
        exp_t e;
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            cyc();
            t++;
        end
        chk("in_ready_wait", in_ready, 1);
        chk("step_q_valid", q_valid, 0);
        x_plus = xp; x_minus = xm; y_plus = yp; y_minus = ym;
        in_valid = 1'b1;
        sp = {2'b00, xp} + {2'b00, yp} + {2'b00, m_rp};
        sm = {2'b00, xm} + {2'b00, ym} + {2'b00, m_rm};
        e.dig = (sp < sm) ? 2'b01 : 2'b10;
        e.rp  = {sp[BITS-2:0], 1'b0};
        e.rm  = {sm[BITS-2:0], 1'b0};
        e.ov  = m_ovf | (|sp[BITS+1:BITS]) | (|sm[BITS+1:BITS]);
        sb.push_back(e);
        cyc();
        in_valid = 1'b0;
        // Scramble the input bus: the DUT must be working from its latched operands.
        x_plus = BITS'($urandom); x_minus = BITS'($urandom);
        y_plus = BITS'($urandom); y_minus = BITS'($urandom);
        chk("eval_q_valid", q_valid, 1);
        chk("eval_in_ready", in_ready, 0);
        chk("eval_digit", {q_plus, q_minus}, sb[0].dig);
        if (stall > 0) q_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            if (stray) begin
                start = 1'b1;
                in_valid = 1'b1;
            end
            cyc();
            chk("stall_q_valid", q_valid, 1);
            chk("stall_digit", {q_plus, q_minus}, sb[0].dig);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_res_plus", res_plus, m_rp);
            chk("stall_res_minus", res_minus, m_rm);
            chk("stall_done", done, 0);
        end
        start = 1'b0;
        in_valid = 1'b0;
        q_ready = 1'b1;
        e = sb.pop_front();
        chk("accept_digit", {q_plus, q_minus}, e.dig);
        cyc();
        m_rp = e.rp; m_rm = e.rm; m_ovf = e.ov;
        chk("res_plus", res_plus, m_rp);
        chk("res_minus", res_minus, m_rm);
        chk("post_q_valid", q_valid, 0);
        chk("post_done", done, last);
    endtask

    task automatic finish_op();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_ovf", ovf, m_ovf);
        cyc();
        chk("done_once", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_ovf_hold", ovf, m_ovf);
        chk("idle_res_hold", res_plus, m_rp);
    endtask

    task automatic run_op(input logic [BITS-1:0] xp, input logic [BITS-1:0] xm,
                          input logic [BITS-1:0] yp, input logic [BITS-1:0] ym,
                          input int stall_iter, input int stall_n, input bit stray);
        do_start();
        for (int i = 0; i < ITER; i++)
            send_pair(xp, xm, yp, ym, (i == stall_iter) ? stall_n : 0, stray, i == ITER - 1);
        finish_op();
    endtask

    initial begin
        m_rp = '0; m_rm = '0; m_ovf = 1'b0;
        @(negedge clk);

        // Reset for two cycles
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_q", {q_plus, q_minus}, 0);
        chk("rst_res", {res_plus, res_minus}, 0);
        chk("rst_ovf", ovf, 0);

        // in_valid while idle is ignored
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("idle_ignore_busy", busy, 0);
        chk("idle_ignore_in_ready", in_ready, 0);

        // Positive run: digits +1, residues 6, 18, 42, 90
        run_op(8'd3, 8'd0, 8'd0, 8'd0, -1, 0, 1'b0);
        chk("pos_final_res", res_plus, 8'h5A);
        chk("pos_ovf", ovf, 0);

        // Negative run with backpressure on iteration 2
        run_op(8'd0, 8'd5, 8'd0, 8'd0, 1, 3, 1'b0);
        chk("neg_res_plus_zero", res_plus, 0);

        // Reset during STEP of iteration 2
        do_start();
        send_pair(8'd3, 8'd0, 8'd0, 8'd0, 0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        sb.delete();
        m_rp = '0; m_rm = '0; m_ovf = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_res", {res_plus, res_minus}, 0);
        run_op(8'd7, 8'd2, 8'd1, 8'd4, -1, 0, 1'b0);

        // Overflow with stray start/in_valid during a stalled EVAL
        run_op(8'hFF, 8'd0, 8'hFF, 8'd0, 2, 2, 1'b1);
        chk("ovf_set", ovf, 1);
        do_start();
        chk("ovf_cleared", ovf, 0);
        send_pair(8'd1, 8'd9, 8'd2, 8'd0, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
